// File: rtl/charlieplex_pwm_scanner.sv
// Scans PIXELCOUNT LEDs, one SLOT-cycle time slot each, and gates each slot with
// PWM from a double-buffered brightness framebuffer that swaps only on frame boundaries.
module charlieplex_pwm_scanner #(
    parameter int PIXELCOUNT = 12,
    parameter int LEVELBITS  = 4,
    localparam int ADDRBITS  = (PIXELCOUNT > 1) ? $clog2(PIXELCOUNT) : 1
) (
    input  logic                 pixelclock,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [ADDRBITS-1:0]  wr_addr,
    input  logic [LEVELBITS-1:0] wr_level,
    output logic                 wr_ready,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic [ADDRBITS-1:0]  pixel_index,
    output logic                 pixel_enable,
    output logic                 frame_start
);

    localparam logic [ADDRBITS-1:0] LAST_PIXEL = ADDRBITS'(PIXELCOUNT - 1);
    localparam logic [ADDRBITS:0]   PIX_LIMIT  = (ADDRBITS + 1)'(PIXELCOUNT);

    logic [LEVELBITS-1:0] front [PIXELCOUNT];
    logic [LEVELBITS-1:0] back  [PIXELCOUNT];
    logic [LEVELBITS-1:0] phase;
    logic [ADDRBITS-1:0]  pixel;
    logic                 slot_end;
    logic                 wrap;
    logic                 write_ok;

    always_comb begin
        slot_end = (phase == '1);
        wrap     = slot_end && (pixel == LAST_PIXEL);
        write_ok = wr_en && !commit_pending && ({1'b0, wr_addr} < PIX_LIMIT);
    end

    always_ff @(posedge pixelclock or posedge rst) begin
        if (rst) begin
            phase          <= '0;
            pixel          <= '0;
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
        end else begin
            phase <= phase + 1'b1;
            if (slot_end) begin
                pixel <= (pixel == LAST_PIXEL) ? '0 : pixel + 1'b1;
            end

            // Writes are blocked while pending, so back is stable during the copy.
            if (write_ok) begin
                back[wr_addr] <= wr_level;
            end

            if (wrap && commit_pending) begin
                for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
                    front[i] <= back[i];
                end
                commit_pending <= 1'b0;
            end else if (commit && !commit_pending) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Phase SLOT-1 can never be below any level, so every slot ends with a blank cycle.
    always_comb begin
        pixel_index  = pixel;
        pixel_enable = enable && (phase < front[pixel]);
        frame_start  = (pixel == '0) && (phase == '0);
        wr_ready     = !commit_pending;
    end

endmodule

// File: doc/charlieplex_pwm_scanner.md
Name: charlieplex_pwm_scanner

Overview:
- Upstream pixel source for the charlieplexer stage.
- Holds a double-buffered per-pixel brightness framebuffer, written through a simple write port.
- Time-multiplexes pixels, producing the LED index plus a PWM-gated enable.
- pixel_index and pixel_enable connect directly to the charlieplexer's index and enable inputs.

Parameters:
PIXELCOUNT, 12, number of LEDs scanned (indices 0..PIXELCOUNT-1)
LEVELBITS, 4, brightness resolution; SLOT = 2**LEVELBITS cycles per pixel, levels 0..SLOT-1
ADDRBITS (localparam), max(1,$clog2(PIXELCOUNT)), width of wr_addr and pixel_index

Ports:
pixelclock  in  1  single clock; all state advances on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  global display enable; combinationally gates pixel_enable
wr_en  in  1  write strobe into back buffer
wr_addr  in  ADDRBITS  pixel to write
wr_level  in  LEVELBITS  brightness level to write
wr_ready  out  1  high when writes are accepted (= !commit_pending)
commit  in  1  request back->front copy at next frame boundary
commit_pending  out  1  commit requested, copy not yet done
pixel_index  out  ADDRBITS  current LED index (to charlieplexer)
pixel_enable  out  1  drive current LED this cycle
frame_start  out  1  high for exactly the first cycle of each frame

Behaviour:
- Reset (async, immediate): front[] and back[] all 0; phase=0, pixel=0, commit_pending=0; outputs pixel_index=0, pixel_enable=0, frame_start=1 (reset state is frame start), wr_ready=1.
- Counters: phase is LEVELBITS wide and increments every cycle. When phase==SLOT-1, it wraps to 0 and pixel advances. Pixel wraps from PIXELCOUNT-1 to 0.
- Frame length: PIXELCOUNT*SLOT cycles.
- The wrap edge is the edge where phase==SLOT-1 and pixel==PIXELCOUNT-1.
- Outputs are combinational from registers, with no pipeline latency:
  - pixel_index = pixel
  - pixel_enable = enable & (phase < front[pixel])
  - frame_start = (pixel==0 && phase==0)
- Brightness: level L gives L on-cycles at phases 0..L-1 of the slot.
  - Phase SLOT-1 is always dark, giving a guaranteed 1-cycle blank between pixels (no ghosting).
  - Level 0 is never lit. Level SLOT-1 gives SLOT-1 of SLOT cycles lit.
- Write port:
  - A write is accepted when wr_en && wr_ready && wr_addr<PIXELCOUNT; back[wr_addr] <= wr_level at that edge.
  - wr_addr >= PIXELCOUNT: ignored, no state change.
  - wr_en while wr_ready=0: dropped (no error flag).
- Commit:
  - commit=1 while commit_pending=0 sets commit_pending on that edge.
  - commit while already pending has no extra effect.
  - A write accepted on the same edge as commit is included in the commit (back is updated on that edge, before any later copy).
- Swap:
  - On a wrap edge with commit_pending=1 (registered value): front[i] <= back[i] for all i, and commit_pending <= 0.
  - Back buffer keeps its contents, so partial updates accumulate.
  - A commit asserted on the wrap edge itself only sets pending; its swap occurs one frame later.
  - The frame following the swap displays the new levels starting at pixel 0, phase 0. No frame ever mixes old and new data.
- Changing enable mid-slot takes effect the same cycle and does not alter scan timing.
- Reset mid-frame or mid-pending: everything returns to reset values and the pending commit is discarded.

Test Plan:
(All with PIXELCOUNT=3, LEVELBITS=2: SLOT=4, frame=12 cycles.)
- Reset, enable=1, no writes, run 24 cycles -> pixel_index sequence 0,0,0,0,1,1,1,1,2,2,2,2 repeating; pixel_enable always 0; frame_start high at cycles 0 and 12 only.
- Write back[0]=1, back[1]=2, back[2]=3, then commit mid-frame -> commit_pending=1 and wr_ready=0 until the wrap edge. The next frame shows pixel_enable per slot of 1,0,0,0 | 1,1,0,0 | 1,1,1,0. Phase 3 is always 0.
- While commit_pending=1, write back[1]=0 -> dropped; after swap pixel 1 still shows level 2.
- Commit asserted exactly on the wrap cycle -> no swap at that edge (old levels for one more frame); swap at the following wrap.
- wr_addr=3 write with level 3 -> no state change; all pixels unchanged. Then toggle enable=0 for cycles 5-6 of a lit frame -> pixel_enable 0 exactly those cycles; index sequence unaffected.
- Assert rst for 1 cycle mid-frame while commit_pending=1 -> outputs immediately pixel_index=0, pixel_enable=0, commit_pending=0, wr_ready=1; frame restarts with frame_start=1 after release.
